// File: rtl/stack_data_memory.sv
// Word data memory with an integrated hardware stack for the memory stage (load/store, PUSH/POP).
// Define DMEM_STACK_CHECK_EN to suppress push-on-full / pop-on-empty and flag them in stack_err.
module stack_data_memory #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned STACK_BASE  = 192,
  parameter int unsigned STACK_DEPTH = 64,
  localparam int unsigned SP_W       = $clog2(STACK_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic [SP_W-1:0]   sp,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  localparam int unsigned IDX_W  = ADDR_W - 2;
  localparam int unsigned MEM_AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [SP_W-1:0]   sp_q, sp_d, sp_dec;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;

  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              stack_op, mem_en, do_read, do_write;
  logic              push_ok, pop_ok, we;
  logic [MEM_AW-1:0] push_addr, pop_addr, waddr, raddr;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^address[1:0];

  assign sp          = sp_q;
  assign data_out    = data_q;
  assign rd_valid    = rd_valid_q;
  assign stack_err   = err_q;
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);

  always_comb begin
    idx       = address[ADDR_W-1:2];
    in_range  = (idx < IDX_W'(DEPTH));
    stack_op  = push ^ pop;
    // push & pop together is illegal: neither happens, but memory ops still go ahead
    mem_en    = ~stack_op;
    do_read   = mem_en & mem_read;
    do_write  = mem_en & mem_write;
    sp_dec    = sp_q - SP_W'(1);
    push_addr = MEM_AW'(STACK_BASE) + MEM_AW'(sp_q[SP_W-2:0]);
    pop_addr  = MEM_AW'(STACK_BASE) + MEM_AW'(sp_dec[SP_W-2:0]);
`ifdef DMEM_STACK_CHECK_EN
    push_ok   = push & ~pop & ~stack_full;
    pop_ok    = pop & ~push & ~stack_empty;
`else
    push_ok   = push & ~pop;
    pop_ok    = pop & ~push;
`endif
    we        = ~reset & (push_ok | (do_write & in_range));
    waddr     = push_ok ? push_addr : idx[MEM_AW-1:0];
    raddr     = pop_ok ? pop_addr : idx[MEM_AW-1:0];
  end

  always_comb begin
    sp_d       = sp_q;
    data_d     = data_q;
    rd_valid_d = 1'b0;
    if (push_ok) begin
      sp_d = sp_q + SP_W'(1);
    end else if (pop_ok) begin
      sp_d = sp_dec;
    end
    if (pop_ok) begin
      data_d     = mem[raddr];
      rd_valid_d = 1'b1;
    end else if (do_read) begin
      data_d     = in_range ? mem[raddr] : '0;
      rd_valid_d = 1'b1;
    end
    err_d = err_q | (push & pop) | (stack_op & (mem_read | mem_write))
          | ((do_read | do_write) & ~in_range);
`ifdef DMEM_STACK_CHECK_EN
    err_d = err_d | (push & ~pop & stack_full) | (pop & ~push & stack_empty);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q       <= '0;
      data_q     <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sp_q       <= sp_d;
      data_q     <= data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // Contents survive reset; the read above sees pre-edge data (read-before-write)
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= data_in;
    end
  end

endmodule

// File: tb/tb_stack_data_memory.sv
// Directed self-checking bench for stack_data_memory (default parameters).
module tb_stack_data_memory;

  localparam int unsigned SP_W = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, push = 1'b0, pop = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        rd_valid;
  logic [SP_W-1:0] sp;
  logic        stack_full, stack_empty, stack_err;

  int n_vec = 0;
  int n_err = 0;

  stack_data_memory dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .push       (push),
    .pop        (pop),
    .address    (address),
    .data_in    (data_in),
    .data_out   (data_out),
    .rd_valid   (rd_valid),
    .sp         (sp),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of requests, sample #1 after the edge, then idle the inputs
  task automatic step(input logic rst, input logic rd, input logic wr, input logic pu,
                      input logic po, input logic [31:0] a, input logic [31:0] d);
    reset = rst; mem_read = rd; mem_write = wr; push = pu; pop = po;
    address = a; data_in = d;
    @(posedge clk);
    #1;
    reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; push = 1'b0; pop = 1'b0;
    address = '0; data_in = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_dout"}, data_out, 32'h0);
    check({tag, "_rdv"}, {31'b0, rd_valid}, 32'h0);
    check({tag, "_sp"}, {25'b0, sp}, 32'h0);
    check({tag, "_empty"}, {31'b0, stack_empty}, 32'h1);
    check({tag, "_full"}, {31'b0, stack_full}, 32'h0);
    check({tag, "_err"}, {31'b0, stack_err}, 32'h0);
  endtask

  initial begin
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0);
    check_reset_state("rst");

    // LIFO order
    step(0, 0, 0, 1, 0, 0, 32'hA);
    check("push1_sp", {25'b0, sp}, 32'd1);
    step(0, 0, 0, 1, 0, 0, 32'hB);
    step(0, 0, 0, 1, 0, 0, 32'hC);
    check("push3_sp", {25'b0, sp}, 32'd3);
    check("push3_empty", {31'b0, stack_empty}, 32'h0);
    step(0, 0, 0, 0, 1, 0, 0);
    check("pop1_data", data_out, 32'hC);
    check("pop1_rdv", {31'b0, rd_valid}, 32'h1);
    check("pop1_sp", {25'b0, sp}, 32'd2);
    step(0, 0, 0, 0, 1, 0, 0);
    check("pop2_data", data_out, 32'hB);
    check("pop2_rdv", {31'b0, rd_valid}, 32'h1);
    step(0, 0, 0, 0, 1, 0, 0);
    check("pop3_data", data_out, 32'hA);
    check("pop3_sp", {25'b0, sp}, 32'd0);
    check("pop3_empty", {31'b0, stack_empty}, 32'h1);
    step(0, 0, 0, 0, 0, 0, 0);
    check("idle_rdv", {31'b0, rd_valid}, 32'h0);
    check("idle_hold", data_out, 32'hA);
    check("lifo_err", {31'b0, stack_err}, 32'h0);

    // Byte-address low bits ignored
    step(0, 0, 1, 0, 0, 32'h10, 32'hDEADBEEF);
    check("wr_rdv", {31'b0, rd_valid}, 32'h0);
    step(0, 1, 0, 0, 0, 32'h13, 0);
    check("rd13_data", data_out, 32'hDEADBEEF);
    check("rd13_rdv", {31'b0, rd_valid}, 32'h1);

    // Read-before-write on the same word
    step(0, 0, 1, 0, 0, 32'h20, 32'h1);
    step(0, 1, 1, 0, 0, 32'h20, 32'h5);
    check("rbw_old", data_out, 32'h1);
    step(0, 1, 0, 0, 0, 32'h20, 0);
    check("rbw_new", data_out, 32'h5);
    check("rbw_err", {31'b0, stack_err}, 32'h0);

    // Push wins over mem_write; collision is sticky
    step(0, 0, 1, 0, 0, 32'h30, 32'h77);
    step(0, 0, 1, 1, 0, 32'h30, 32'h99);
    check("coll_sp", {25'b0, sp}, 32'd1);
    check("coll_err", {31'b0, stack_err}, 32'h1);
    step(0, 1, 0, 0, 0, 32'h30, 0);
    check("coll_mem", data_out, 32'h77);
    step(0, 0, 0, 0, 1, 0, 0);
    check("coll_pop", data_out, 32'h99);
    check("coll_err_sticky", {31'b0, stack_err}, 32'h1);
    step(1, 0, 0, 0, 0, 0, 0);
    check_reset_state("rst2");

    // push & pop together: neither, err set, mem_write still executes
    step(0, 0, 1, 1, 1, 32'h40, 32'h42);
    check("pp_sp", {25'b0, sp}, 32'd0);
    check("pp_err", {31'b0, stack_err}, 32'h1);
    step(0, 1, 0, 0, 0, 32'h40, 0);
    check("pp_memwr", data_out, 32'h42);
    step(1, 0, 0, 0, 0, 0, 0);

    // Fill the stack; word 192 = byte 0x300
    for (int i = 0; i < 64; i++) begin
      step(0, 0, 0, 1, 0, 0, 32'h100 + i);
    end
    check("fill_sp", {25'b0, sp}, 32'd64);
    check("fill_full", {31'b0, stack_full}, 32'h1);
    check("fill_err", {31'b0, stack_err}, 32'h0);
    step(0, 0, 0, 1, 0, 0, 32'hFFFF);
    step(0, 1, 0, 0, 0, 32'h300, 0);
`ifdef DMEM_STACK_CHECK_EN
    check("ovf_sp", {25'b0, sp}, 32'd64);
    check("ovf_full", {31'b0, stack_full}, 32'h1);
    check("ovf_err", {31'b0, stack_err}, 32'h1);
    check("ovf_base", data_out, 32'h100);
`else
    check("ovf_sp", {25'b0, sp}, 32'd65);
    check("ovf_full", {31'b0, stack_full}, 32'h0);
    check("ovf_err", {31'b0, stack_err}, 32'h0);
    check("ovf_base", data_out, 32'hFFFF);
`endif
    step(1, 0, 0, 0, 0, 0, 0);

    // Pop on empty
    step(0, 0, 0, 0, 1, 0, 0);
`ifdef DMEM_STACK_CHECK_EN
    check("unf_sp", {25'b0, sp}, 32'd0);
    check("unf_rdv", {31'b0, rd_valid}, 32'h0);
    check("unf_err", {31'b0, stack_err}, 32'h1);
`else
    check("unf_sp", {25'b0, sp}, 32'h7F);
    check("unf_rdv", {31'b0, rd_valid}, 32'h1);
    check("unf_err", {31'b0, stack_err}, 32'h0);
`endif
    step(1, 0, 0, 0, 0, 0, 0);

    // Out-of-range read returns 0 and flags error
    step(0, 1, 0, 0, 0, 32'h10, 0);
    check("pre_oor", data_out, 32'hDEADBEEF);
    step(0, 1, 0, 0, 0, 32'h400, 0);
    check("oor_data", data_out, 32'h0);
    check("oor_rdv", {31'b0, rd_valid}, 32'h1);
    check("oor_err", {31'b0, stack_err}, 32'h1);

    // Reset mid-sequence, with a request in the same cycle
    step(0, 0, 0, 1, 0, 0, 32'h55);
    step(0, 0, 0, 0, 1, 0, 0);
    check("mid_pop", data_out, 32'h55);
    step(0, 0, 0, 1, 0, 0, 32'h66);
    step(1, 1, 0, 1, 0, 32'h10, 32'h77);
    check_reset_state("rst_mid");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stack_data_memory.md
# stack_data_memory

Parametrised single-port word data memory with an integrated hardware stack, used by the processor's memory stage for load/store and PUSH/POP instructions. It generalises the existing data memory in width, depth and stack placement. Over the existing block it adds explicit push/pop strobes, a bounded stack region, full/empty status, a registered read-valid strobe and a defined priority when requests collide.

## Interface
Parameters:
- DATA_W, 32, data word width in bits
- ADDR_W, 32, byte-address width
- DEPTH, 256, memory size in words
- STACK_BASE, 192, word index of the first stack entry
- STACK_DEPTH, 64, stack capacity in words; power of two; STACK_BASE+STACK_DEPTH ≤ DEPTH

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- mem_read  in  1  load request
- mem_write  in  1  store request
- push  in  1  push data_in onto stack
- pop  in  1  pop top of stack to data_out
- address  in  ADDR_W  byte address; word index = address[ADDR_W-1:2]
- data_in  in  DATA_W  store/push data
- data_out  out  DATA_W  registered load/pop data
- rd_valid  out  1  data_out updated this cycle
- sp  out  SP_W  entry count, SP_W = log2(STACK_DEPTH)+1
- stack_full  out  1  sp == STACK_DEPTH
- stack_empty  out  1  sp == 0
- stack_err  out  1  sticky error flag

## Operation
- Priority per cycle, highest first: push, pop, mem_write/mem_read.
- push & pop together: illegal; neither performed, sp unchanged, stack_err set. mem ops that cycle still execute.
- Stack op present (legal): mem_read/mem_write that cycle dropped, stack_err set (collision).
- push: memory[STACK_BASE + sp[SP_W-2:0]] <= data_in; sp <= sp+1.
- pop: data_out <= memory[STACK_BASE + (sp-1)[SP_W-2:0]]; sp <= sp-1; rd_valid next cycle.
- mem_write: memory[idx] <= data_in if idx < DEPTH; else ignored and stack_err set. address[1:0] ignored.
- mem_read: data_out <= memory[idx] if idx < DEPTH, else 0 and stack_err set; rd_valid pulses.
- mem_read & mem_write same address, same cycle: both performed; read returns old contents (read-before-write).
- Stack region is ordinary memory; loads/stores may address it without restriction.
- stack_err clears only on reset.
- No request: data_out holds, rd_valid 0.

## Timing
- Read/pop latency 1: request sampled at edge N, data_out and rd_valid=1 visible after edge N; rd_valid is a 1-cycle pulse per request.
- Write/push committed at edge N; a read of the same word at edge N+1 returns new data.
- sp, stack_full, stack_empty registered; update after the edge that performs the push/pop.
- Reset values: data_out 0, rd_valid 0, sp 0, stack_empty 1, stack_full 0, stack_err 0. Memory contents not cleared.
- Reset asserted with any request in the same cycle: reset wins; no write, no sp change.
- Back-to-back push/pop every cycle sustained, no bubbles.

## Configuration
- DMEM_STACK_CHECK_EN defined: push when stack_full and pop when stack_empty suppressed (no write, sp unchanged, data_out holds, rd_valid 0), stack_err set.
- Not defined: no bound checking. sp wraps modulo 2^SP_W, and addressing uses the low SP_W-1 bits, so an overflowing push overwrites STACK_BASE onward. Pop on empty sets sp to all-ones and reads STACK_BASE+STACK_DEPTH-1. Overflow/underflow do not set stack_err; the collision and range errors still do.

## Test plan
- Reset, then push 0xA, 0xB, 0xC on consecutive cycles, then 3 pops -> data_out 0xC, 0xB, 0xA, each with rd_valid one cycle after its pop; sp 3 then 0; stack_empty 1 at end.
- mem_write address 0x10 data 0xDEADBEEF, next cycle mem_read 0x13 -> data_out 0xDEADBEEF after 1 cycle (low bits ignored).
- Same-cycle mem_write 0x20 data 0x5 and mem_read 0x20 (old value 0x1) -> data_out 0x1; next read -> 0x5.
- push and mem_write in the same cycle -> push performed, memory at write address unchanged, stack_err 1 until reset.
- With DMEM_STACK_CHECK_EN: 64 pushes, then a 65th -> stack_full 1, sp 64, stack_err 1, memory[STACK_BASE] intact. Without the macro: the 65th push overwrites memory[STACK_BASE] and sp = 65.
- mem_read at address 0x400 (word 256 ≥ DEPTH) -> data_out 0, rd_valid 1, stack_err 1. Reset mid-sequence -> all outputs return to reset values the next cycle.
